// File: rtl/count_display_module.sv
// count_display_module
//
// Extends the decade counter's ones digit to two decimal digits and drives a
// two-digit, time-multiplexed, active-low seven-segment display.
//
// The tens digit steps on each rising edge of the counter's registered zero
// flag. The first such edge after reset is the counter's power-up artifact
// and is absorbed, because the counter sits at 0 straight out of reset.
//
// Parameters
//   SCAN_DIV  cycles each digit is lit per scan slot (2..65535)
//   BLANK_LZ  1 = blank the tens digit while it is 0
//
// Ports
//   clk     rising-edge clock, shared with the counter stage
//   rst     synchronous active-high reset
//   mode    count direction: 1 = up, 0 = down
//   number  ones digit from the counter (0..9; anything else shows blank)
//   zero    counter's registered "ones was 0" flag
//   tens    registered tens digit, 0..9
//   wrap    one-cycle pulse when tens crosses the 9/0 boundary
//   seg     active-low segments, seg[0] = a ... seg[6] = g
//   an      active-low digit enables, an[0] = ones, an[1] = tens

module count_display_module #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [3:0] number,
    input  logic       zero,
    output logic [3:0] tens,
    output logic       wrap,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

    logic        zero_q;
    logic        armed;
    logic        zero_rise;
    logic        evt;
    logic [15:0] scan_cnt;
    logic        digit_sel;
    logic [3:0]  src_digit;
    logic [6:0]  seg_next;

    assign zero_rise = zero & ~zero_q;
    assign evt       = zero_rise & armed;

    // Zero edge detection, arming and tens digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            armed  <= 1'b0;
            tens   <= 4'd0;
            wrap   <= 1'b0;
        end else begin
            zero_q <= zero;
            wrap   <= 1'b0;
            if (zero_rise) begin
                armed <= 1'b1;
            end
            if (evt) begin
                if (mode) begin
                    if (tens == 4'd9) begin
                        tens <= 4'd0;
                        wrap <= 1'b1;
                    end else begin
                        tens <= tens + 4'd1;
                    end
                end else begin
                    if (tens == 4'd0) begin
                        tens <= 4'd9;
                        wrap <= 1'b1;
                    end else begin
                        tens <= tens - 4'd1;
                    end
                end
            end
        end
    end

    // Scan timer: each digit slot lasts SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= 16'd0;
            digit_sel <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= 16'd0;
            digit_sel <= ~digit_sel;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    assign src_digit = digit_sel ? tens : number;

    always_comb begin
        seg_next = 7'h7F;
        case (src_digit)
            4'd0:    seg_next = 7'h40;
            4'd1:    seg_next = 7'h79;
            4'd2:    seg_next = 7'h24;
            4'd3:    seg_next = 7'h30;
            4'd4:    seg_next = 7'h19;
            4'd5:    seg_next = 7'h12;
            4'd6:    seg_next = 7'h02;
            4'd7:    seg_next = 7'h78;
            4'd8:    seg_next = 7'h00;
            4'd9:    seg_next = 7'h10;
            default: seg_next = 7'h7F;
        endcase
        // Leading-zero blanking keeps the digit enable asserted so the scan
        // duty cycle stays constant.
        if (digit_sel && BLANK_LZ && tens == 4'd0) begin
            seg_next = 7'h7F;
        end
    end

    // Output register: seg and an change together, one cycle after digit_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 7'h7F;
            an  <= 2'b11;
        end else begin
            seg <= seg_next;
            an  <= digit_sel ? 2'b01 : 2'b10;
        end
    end

endmodule
